alu_issue_ctrl: RTL and testbench

- Initiator side of the 4-bit ALU interface.
- Accepts 16-bit instructions over a valid/ready handshake and reads operands from an internal 4x4-bit register file.
- Drives op/a/b to an external ALU instance and captures its result and [N,Z,V,C] flags.
- Performs conditional execution against a latched flag register, writes back, and returns a response over a second valid/ready handshake.
- Sits between the fetch stage and the ALU in the SIPS4 datapath.

---
 rtl/sips4_pkg.sv | 73 +++++++
 rtl/sips4_regfile.sv | 31 +++
 rtl/alu_issue_ctrl.sv | 135 +++++++++++++
 tb/tb_alu_issue_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sips4_pkg.sv
// Shared definitions for the SIPS4 ALU issue path: opcodes, condition codes,
// instruction field positions, flag indices and issue FSM encoding.
package sips4_pkg;

  localparam int unsigned OP_MSB      = 15;
  localparam int unsigned OP_LSB      = 12;
  localparam int unsigned RD_MSB      = 11;
  localparam int unsigned RD_LSB      = 10;
  localparam int unsigned RA_MSB      = 9;
  localparam int unsigned RA_LSB      = 8;
  localparam int unsigned USE_IMM_BIT = 7;
  localparam int unsigned COND_MSB    = 6;
  localparam int unsigned COND_LSB    = 4;
  localparam int unsigned IMM_MSB     = 3;
  localparam int unsigned IMM_LSB     = 0;
  localparam int unsigned RB_MSB      = 1;
  localparam int unsigned RB_LSB      = 0;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_C = 0;

  typedef enum logic [3:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_AND = 4'h2,
    OP_OR  = 4'h3,
    OP_XOR = 4'h4,
    OP_LSL = 4'h8,
    OP_LSR = 4'h9,
    OP_ASR = 4'hA
  } opcode_e;

  typedef enum logic [2:0] {
    COND_AL = 3'b000,
    COND_EQ = 3'b001,
    COND_NE = 3'b010,
    COND_MI = 3'b011,
    COND_CS = 3'b100,
    COND_VS = 3'b101,
    COND_CC = 3'b110,
    COND_NV = 3'b111
  } cond_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_LSL, OP_LSR, OP_ASR: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

  function automatic logic cond_true(input logic [2:0] cond, input logic [3:0] flags);
    case (cond)
      COND_AL: return 1'b1;
      COND_EQ: return flags[FLAG_Z];
      COND_NE: return !flags[FLAG_Z];
      COND_MI: return flags[FLAG_N];
      COND_CS: return flags[FLAG_C];
      COND_VS: return flags[FLAG_V];
      COND_CC: return !flags[FLAG_C];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sips4_regfile.sv
// 4 x 4-bit register file: two combinational read ports, one synchronous write port.
module sips4_regfile
  import sips4_pkg::*;
#(
  parameter logic [3:0] REG_RESET = 4'h0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [1:0] waddr,
  input  logic [3:0] wdata,
  input  logic [1:0] raddr_a,
  output logic [3:0] rdata_a,
  input  logic [1:0] raddr_b,
  output logic [3:0] rdata_b
);

  logic [3:0] regs [4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) regs[i] <= REG_RESET;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller between fetch and an external 4-bit ALU: accepts one
// instruction, executes it conditionally for one cycle, then holds the response.
module alu_issue_ctrl
  import sips4_pkg::*;
#(
  parameter logic [3:0] FLAGS_RESET = 4'b0000,
  parameter logic [3:0] REG_RESET   = 4'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_instr,
  output logic [3:0]  alu_op,
  output logic [3:0]  alu_a,
  output logic [3:0]  alu_b,
  input  logic [3:0]  alu_result,
  input  logic [3:0]  alu_flags,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_data,
  output logic [3:0]  out_flags,
  output logic        out_skipped,
  output logic        out_illegal,
  output logic [3:0]  flags_q
);

  state_e      state;
  logic [15:0] instr_q;
  logic [3:0]  op_hold;
  logic [3:0]  a_hold;
  logic [3:0]  b_hold;

  logic [3:0]  op_field;
  logic [1:0]  rd_field;
  logic [1:0]  ra_field;
  logic [1:0]  rb_field;
  logic [2:0]  cond_field;
  logic [3:0]  imm_field;
  logic        use_imm;

  logic [3:0]  rdata_a;
  logic [3:0]  rdata_b;
  logic [3:0]  operand_b;
  logic        legal;
  logic        take;
  logic        we;

  assign op_field   = instr_q[OP_MSB:OP_LSB];
  assign rd_field   = instr_q[RD_MSB:RD_LSB];
  assign ra_field   = instr_q[RA_MSB:RA_LSB];
  assign rb_field   = instr_q[RB_MSB:RB_LSB];
  assign cond_field = instr_q[COND_MSB:COND_LSB];
  assign imm_field  = instr_q[IMM_MSB:IMM_LSB];
  assign use_imm    = instr_q[USE_IMM_BIT];

  assign operand_b = use_imm ? imm_field : rdata_b;
  assign legal     = op_legal(op_field);
  assign take      = cond_true(cond_field, flags_q);
  assign we        = (state == ST_EXEC) && legal && take;

  sips4_regfile #(
    .REG_RESET (REG_RESET)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (we),
    .waddr   (rd_field),
    .wdata   (alu_result),
    .raddr_a (ra_field),
    .rdata_a (rdata_a),
    .raddr_b (rb_field),
    .rdata_b (rdata_b)
  );

  // Outside EXEC the ALU inputs repeat the last issued operation instead of toggling.
  assign alu_op = (state == ST_EXEC) ? op_field  : op_hold;
  assign alu_a  = (state == ST_EXEC) ? rdata_a   : a_hold;
  assign alu_b  = (state == ST_EXEC) ? operand_b : b_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      in_ready    <= 1'b1;
      instr_q     <= '0;
      op_hold     <= '0;
      a_hold      <= '0;
      b_hold      <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_flags   <= FLAGS_RESET;
      out_skipped <= 1'b0;
      out_illegal <= 1'b0;
      flags_q     <= FLAGS_RESET;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            instr_q  <= in_instr;
            in_ready <= 1'b0;
            state    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          op_hold     <= op_field;
          a_hold      <= rdata_a;
          b_hold      <= operand_b;
          out_illegal <= !legal;
          out_skipped <= legal && !take;
          out_valid   <= 1'b1;
          state       <= ST_RESP;
          if (we) begin
            flags_q   <= alu_flags;
            out_flags <= alu_flags;
            out_data  <= alu_result;
          end else begin
            out_flags <= flags_q;
          end
        end
        ST_RESP: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state    <= ST_IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU, transaction-level reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_instr = '0;
  logic [3:0]  alu_op, alu_a, alu_b;
  logic [3:0]  alu_result, alu_flags;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  out_data, out_flags;
  logic        out_skipped, out_illegal;
  logic [3:0]  flags_q;

  int vectors = 0;
  int errors  = 0;
  bit started = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .alu_op      (alu_op),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_result  (alu_result),
    .alu_flags   (alu_flags),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_flags   (out_flags),
    .out_skipped (out_skipped),
    .out_illegal (out_illegal),
    .flags_q     (flags_q)
  );

  // Returns {N,Z,V,C,result}
  function automatic logic [7:0] alu_ref(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    logic [3:0] r;
    logic       v, c;
    s = '0; r = '0; v = 1'b0; c = 1'b0;
    case (op)
      4'h0: begin s = {1'b0, a} + {1'b0, b}; r = s[3:0]; c = s[4]; v = (a[3] == b[3]) && (r[3] != a[3]); end
      4'h1: begin r = a - b; c = (a < b); v = (a[3] != b[3]) && (r[3] != a[3]); end
      4'h2: r = a & b;
      4'h3: r = a | b;
      4'h4: r = a ^ b;
      4'h8: r = a << b;
      4'h9: r = a >> b;
      4'hA: r = 4'($signed(a) >>> b);
      default: r = '0;
    endcase
    return {r[3], (r == 4'h0), v, c, r};
  endfunction

  always_comb {alu_flags, alu_result} = alu_ref(alu_op, alu_a, alu_b);

  function automatic bit cond_ok(input logic [2:0] c, input logic [3:0] f);
    case (c)
      3'd0: return 1'b1;
      3'd1: return f[2];
      3'd2: return !f[2];
      3'd3: return f[3];
      3'd4: return f[0];
      3'd5: return f[1];
      3'd6: return !f[0];
      default: return 1'b0;
    endcase
  endfunction

  // Reference model: phase 0 waiting, 1 executing, 2 responding.
  int         m_phase = 0;
  logic [3:0] m_regs [4] = '{default: 4'h0};
  logic [3:0] m_flags = 4'h0;
  logic [3:0] m_out_flags = 4'h0;
  logic [3:0] m_out_data = 4'h0;
  bit         m_skip = 0;
  bit         m_ill = 0;
  logic [15:0] m_instr = '0;
  logic [3:0] m_op = '0, m_a = '0, m_b = '0;

  task automatic model_reset();
    m_phase = 0;
    for (int i = 0; i < 4; i++) m_regs[i] = 4'h0;
    m_flags = 4'h0; m_out_flags = 4'h0; m_out_data = 4'h0;
    m_skip = 0; m_ill = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    logic [7:0] res;
    if (!rst_n) begin
      model_reset();
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          m_instr = in_instr;
          m_op = in_instr[15:12];
          m_a  = m_regs[in_instr[9:8]];
          m_b  = in_instr[7] ? in_instr[3:0] : m_regs[in_instr[1:0]];
          m_phase = 1;
        end
        1: begin
          res = alu_ref(m_op, m_a, m_b);
          if (!(m_op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h8, 4'h9, 4'hA})) begin
            m_ill = 1; m_skip = 0;
          end else if (!cond_ok(m_instr[6:4], m_flags)) begin
            m_ill = 0; m_skip = 1;
          end else begin
            m_ill = 0; m_skip = 0;
            m_regs[m_instr[11:10]] = res[3:0];
            m_flags = res[7:4];
            m_out_data = res[3:0];
          end
          m_out_flags = m_flags;
          m_phase = 2;
        end
        default: if (out_ready) m_phase = 0;
      endcase
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("in_ready",    16'(in_ready),    16'(m_phase == 0));
      chk("out_valid",   16'(out_valid),   16'(m_phase == 2));
      chk("flags_q",     16'(flags_q),     16'(m_flags));
      chk("out_flags",   16'(out_flags),   16'(m_out_flags));
      chk("out_data",    16'(out_data),    16'(m_out_data));
      chk("out_skipped", 16'(out_skipped), 16'(m_skip));
      chk("out_illegal", 16'(out_illegal), 16'(m_ill));
      if (m_phase == 1) begin
        chk("alu_op", 16'(alu_op), 16'(m_op));
        chk("alu_a",  16'(alu_a),  16'(m_a));
        chk("alu_b",  16'(alu_b),  16'(m_b));
      end
    end
  end

  // Offers ins until accepted, then walks into the response phase.
  task automatic issue(input logic [15:0] ins);
    bit acc = 0;
    in_valid = 1'b1;
    in_instr = ins;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(posedge clk); #1;
      if (m_phase == 1) acc = 1;
    end
    in_valid = 1'b0;
    chk("accept_timeout", 16'(acc), 16'd1);
    chk("exec_out_valid", 16'(out_valid), 16'd0);
    chk("exec_in_ready",  16'(in_ready),  16'd0);
    @(posedge clk); #1;
    chk("resp_out_valid", 16'(out_valid), 16'd1);
  endtask

  task automatic release_resp(input int stall);
    logic [3:0] held;
    held = out_data;
    if (stall > 0) begin
      in_valid = 1'b1;
      in_instr = 16'h0485;
    end
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("stall_in_ready",  16'(in_ready),  16'd0);
      chk("stall_out_valid", 16'(out_valid), 16'd1);
      chk("stall_out_data",  16'(out_data),  16'(held));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_hs_out_valid", 16'(out_valid), 16'd0);
    chk("post_hs_in_ready",  16'(in_ready),  16'd1);
  endtask

  task automatic expect_resp(input string tag, input logic [3:0] d, input logic [3:0] f,
                             input logic sk, input logic il);
    chk({tag, "_data"},    16'(out_data),    16'(d));
    chk({tag, "_flags"},   16'(out_flags),   16'(f));
    chk({tag, "_skipped"}, 16'(out_skipped), 16'(sk));
    chk({tag, "_illegal"}, 16'(out_illegal), 16'(il));
  endtask

  function automatic logic [15:0] rand_instr();
    logic [3:0] ops [10];
    logic [15:0] r;
    ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h8, 4'h9, 4'hA, 4'h5, 4'hF};
    r = 16'($urandom);
    r[15:12] = ops[$urandom_range(0, 9)];
    if ($urandom_range(0, 1) == 0) r[6:4] = 3'b000;
    return r;
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready",  16'(in_ready),  16'd1);
    chk("rst_out_valid", 16'(out_valid), 16'd0);
    chk("rst_flags_q",   16'(flags_q),   16'h0);
    chk("rst_alu_op",    16'(alu_op),    16'h0);
    chk("rst_alu_a",     16'(alu_a),     16'h0);
    chk("rst_alu_b",     16'(alu_b),     16'h0);
    expect_resp("rst", 4'h0, 4'h0, 1'b0, 1'b0);
    started = 1;

    issue(16'h0485); expect_resp("add5", 4'h5, 4'b0000, 1'b0, 1'b0); release_resp(0);
    issue(16'h1485); expect_resp("sub_r0", 4'hB, 4'b1001, 1'b0, 1'b0); release_resp(0);
    issue(16'h0485); expect_resp("add5b", 4'h5, 4'b0000, 1'b0, 1'b0); release_resp(0);
    issue(16'h1585); expect_resp("sub_r1", 4'h0, 4'b0100, 1'b0, 1'b0); release_resp(0);
    issue(16'h04A5); expect_resp("cond_ne", 4'h0, 4'b0100, 1'b1, 1'b0); release_resp(0);
    issue(16'h0495); expect_resp("cond_eq", 4'h5, 4'b0000, 1'b0, 1'b0); release_resp(0);
    issue(16'h0887); expect_resp("r2_7", 4'h7, 4'b0000, 1'b0, 1'b0); release_resp(0);
    issue(16'h0A81); expect_resp("ovf", 4'h8, 4'b1010, 1'b0, 1'b0); release_resp(0);
    issue(16'h5485); expect_resp("illegal", 4'h8, 4'b1010, 1'b0, 1'b1);
    chk("illegal_flags_q", 16'(flags_q), 16'hA);
    release_resp(3);
    issue(16'h0D00); expect_resp("r1_keep", 4'h5, 4'b0000, 1'b0, 1'b0); release_resp(0);

    // Reset pulse while 0x0487 is in EXEC: R1 must not become 7.
    in_valid = 1'b1; in_instr = 16'h0487;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pre_rst_in_exec", 16'(m_phase), 16'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready",  16'(in_ready),  16'd1);
    chk("arst_out_valid", 16'(out_valid), 16'd0);
    chk("arst_flags_q",   16'(flags_q),   16'h0);
    chk("arst_alu_a",     16'(alu_a),     16'h0);
    expect_resp("arst", 4'h0, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(16'h0D00); expect_resp("post_rst", 4'h0, 4'b0100, 1'b0, 1'b0); release_resp(0);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 1) == 1);
      in_instr  = rand_instr();
      out_ready = ($urandom_range(0, 2) != 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
